// File: rtl/kc705_slv_arb_pkg.sv
// Shared types and configuration for the KC705 slave request arbiter.
// The latched request slot is sized from the slave's native address/data widths.
package kc705_slv_arb_pkg;

  localparam int unsigned CFG_SLV_ARB_NREQ_MAX = 4;
  localparam int unsigned CFG_SLV_ARB_IDX_W    = $clog2(CFG_SLV_ARB_NREQ_MAX);
  localparam int unsigned CFG_SLV_ARB_ABITS    = 4;
  localparam int unsigned CFG_SLV_ARB_DBITS    = 64;
  localparam int unsigned CFG_SLV_ARB_SBITS    = CFG_SLV_ARB_DBITS / 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic                         write;
    logic [CFG_SLV_ARB_ABITS-1:0] addr;
    logic [CFG_SLV_ARB_SBITS-1:0] wstrb;
    logic [CFG_SLV_ARB_DBITS-1:0] wdata;
  } req_slot_t;

endpackage

// File: rtl/kc705_slv_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Emits a one-hot grant and its index; all zero when nothing requests.
module rr_arbiter
  import kc705_slv_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]              req,
  input  logic [CFG_SLV_ARB_IDX_W-1:0] ptr,
  output logic [NREQ-1:0]              grant,
  output logic [CFG_SLV_ARB_IDX_W-1:0] idx
);

  logic [CFG_SLV_ARB_IDX_W-1:0] cand;
  logic [NREQ-1:0]              mask;
  logic                         found;

  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    mask  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = CFG_SLV_ARB_IDX_W'((32'(ptr) + i) % NREQ);
      mask = NREQ'(1) << cand;
      if (!found && |(req & mask)) begin
        found = 1'b1;
        grant = mask;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/kc705_slv_req_arbiter.sv
// Shares the KC705 test-slave request port between NREQ requesters:
// grant -> one-cycle memory strobe -> fixed read-latency wait -> one-cycle response.
module kc705_slv_req_arbiter
  import kc705_slv_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ABITS      = CFG_SLV_ARB_ABITS,
  parameter int unsigned DBITS      = CFG_SLV_ARB_DBITS,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                      i_clk,
  input  logic                      i_nrst,
  input  logic [NREQ-1:0]           i_req_valid,
  output logic [NREQ-1:0]           o_req_ready,
  input  logic [NREQ-1:0]           i_req_write,
  input  logic [NREQ*ABITS-1:0]     i_req_addr,
  input  logic [NREQ*(DBITS/8)-1:0] i_req_wstrb,
  input  logic [NREQ*DBITS-1:0]     i_req_wdata,
  output logic [NREQ-1:0]           o_resp_valid,
  output logic [DBITS-1:0]          o_resp_rdata,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [ABITS-1:0]          o_mem_addr,
  output logic [DBITS/8-1:0]        o_mem_wstrb,
  output logic [DBITS-1:0]          o_mem_wdata,
  input  logic [DBITS-1:0]          i_mem_rdata
);

  localparam int unsigned SW = DBITS / 8;
  localparam int unsigned IW = CFG_SLV_ARB_IDX_W;

  arb_state_t        state, state_nxt;
  logic [IW-1:0]     rr_ptr, gidx, cur;
  logic [NREQ-1:0]   grant;
  req_slot_t         slot, sel;
  logic [1:0]        cnt;
  logic [DBITS-1:0]  rdata_q;
  logic              accept, capture;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (i_req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign accept  = (state == IDLE) && (|i_req_valid);
  assign capture = ((state == ACCESS) && (RD_LATENCY == 0)) ||
                   ((state == WAIT) && (cnt == '0));

  always_comb begin
    sel = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel.write = i_req_write[k];
        sel.addr  = CFG_SLV_ARB_ABITS'(i_req_addr[k*ABITS +: ABITS]);
        sel.wstrb = CFG_SLV_ARB_SBITS'(i_req_wstrb[k*SW +: SW]);
        sel.wdata = CFG_SLV_ARB_DBITS'(i_req_wdata[k*DBITS +: DBITS]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|i_req_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = (RD_LATENCY > 0) ? WAIT : RESP;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      rr_ptr  <= '0;
      cur     <= '0;
      slot    <= '0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cur    <= gidx;
        rr_ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        slot   <= sel;
      end
      if (state == ACCESS)    cnt <= 2'(RD_LATENCY - 1);
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (capture) rdata_q <= slot.write ? '0 : i_mem_rdata;
    end
  end

  always_comb begin
    o_req_ready  = (state == IDLE) ? grant : '0;
    o_mem_req    = (state == ACCESS);
    o_mem_we     = (state == ACCESS) && slot.write;
    o_mem_addr   = ABITS'(slot.addr);
    o_mem_wstrb  = SW'(slot.wstrb);
    o_mem_wdata  = DBITS'(slot.wdata);
    o_resp_valid = (state == RESP) ? (NREQ'(1) << cur) : '0;
    o_resp_rdata = rdata_q;
  end

endmodule

// File: tb/tb_kc705_slv_req_arbiter.sv
// Scoreboard bench for kc705_slv_req_arbiter: three configurations (L=1/N=2, L=3/N=3,
// L=0/N=2) share one clock; an acceptance monitor queues expected accesses/responses.
module tb_kc705_slv_req_arbiter;

  typedef struct {
    int          inst;
    int unsigned cyc;
    int          id;
    logic        we;
    logic [3:0]  addr;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  nrst;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        mon_en  = 1'b0;

  // per-instance stimulus
  logic [3:0]  valid [3];
  logic        wr    [3][4];
  logic [3:0]  adr   [3][4];
  logic [7:0]  stb   [3][4];
  logic [63:0] wd    [3][4];
  logic [3:0]   p_wr  [3];
  logic [15:0]  p_adr [3];
  logic [31:0]  p_stb [3];
  logic [255:0] p_wd  [3];

  // per-instance observed outputs, widened to 4 requesters
  logic [1:0]  rdy_a, rv_a, rdy_c, rv_c;
  logic [2:0]  rdy_b, rv_b;
  logic [3:0]  v_rdy [3];
  logic [3:0]  v_rv  [3];
  logic        v_mreq [3];
  logic        v_mwe  [3];
  logic [3:0]  v_maddr [3];
  logic [7:0]  v_mstrb [3];
  logic [63:0] v_mwd [3];
  logic [63:0] v_rd  [3];
  logic [63:0] v_mrd [3];
  int unsigned age [3] = '{default: 0};

  exp_t qm[$];
  exp_t qr[$];
  int   gq[$];
  int          acc_cnt [3] = '{default: 0};
  int unsigned acc_cyc [3] = '{default: 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned lat(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] mem_val(input logic [3:0] a);
    if (a == 4'h3) return 64'hDEADBEEF_01234567;
    return {16{a}};
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      p_wr[i] = '0; p_adr[i] = '0; p_stb[i] = '0; p_wd[i] = '0;
      for (int k = 0; k < 4; k++) begin
        p_wr[i][k]          = wr[i][k];
        p_adr[i][k*4 +: 4]  = adr[i][k];
        p_stb[i][k*8 +: 8]  = stb[i][k];
        p_wd[i][k*64 +: 64] = wd[i][k];
      end
    end
  end

  // slave model: read data is only valid exactly RD_LATENCY cycles after o_mem_req
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (v_mreq[i])                      age[i] <= 1;
      else if (age[i] != 0 && age[i] < 15) age[i] <= age[i] + 1;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      v_mrd[i] = 64'hBAD0_BAD0_BAD0_BAD0;
      if ((v_mreq[i] && lat(i) == 0) || (!v_mreq[i] && lat(i) != 0 && age[i] == lat(i)))
        v_mrd[i] = mem_val(v_maddr[i]);
    end
  end

  assign v_rdy[0] = {2'b00, rdy_a};
  assign v_rv[0]  = {2'b00, rv_a};
  assign v_rdy[1] = {1'b0, rdy_b};
  assign v_rv[1]  = {1'b0, rv_b};
  assign v_rdy[2] = {2'b00, rdy_c};
  assign v_rv[2]  = {2'b00, rv_c};

  kc705_slv_req_arbiter #(.NREQ(2), .ABITS(4), .DBITS(64), .RD_LATENCY(1)) u_dut (
    .i_clk(clk), .i_nrst(nrst[0]), .i_req_valid(valid[0][1:0]), .o_req_ready(rdy_a),
    .i_req_write(p_wr[0][1:0]), .i_req_addr(p_adr[0][7:0]), .i_req_wstrb(p_stb[0][15:0]),
    .i_req_wdata(p_wd[0][127:0]), .o_resp_valid(rv_a), .o_resp_rdata(v_rd[0]),
    .o_mem_req(v_mreq[0]), .o_mem_we(v_mwe[0]), .o_mem_addr(v_maddr[0]),
    .o_mem_wstrb(v_mstrb[0]), .o_mem_wdata(v_mwd[0]), .i_mem_rdata(v_mrd[0])
  );

  kc705_slv_req_arbiter #(.NREQ(3), .ABITS(4), .DBITS(64), .RD_LATENCY(3)) u_dut_l3 (
    .i_clk(clk), .i_nrst(nrst[1]), .i_req_valid(valid[1][2:0]), .o_req_ready(rdy_b),
    .i_req_write(p_wr[1][2:0]), .i_req_addr(p_adr[1][11:0]), .i_req_wstrb(p_stb[1][23:0]),
    .i_req_wdata(p_wd[1][191:0]), .o_resp_valid(rv_b), .o_resp_rdata(v_rd[1]),
    .o_mem_req(v_mreq[1]), .o_mem_we(v_mwe[1]), .o_mem_addr(v_maddr[1]),
    .o_mem_wstrb(v_mstrb[1]), .o_mem_wdata(v_mwd[1]), .i_mem_rdata(v_mrd[1])
  );

  kc705_slv_req_arbiter #(.NREQ(2), .ABITS(4), .DBITS(64), .RD_LATENCY(0)) u_dut_l0 (
    .i_clk(clk), .i_nrst(nrst[2]), .i_req_valid(valid[2][1:0]), .o_req_ready(rdy_c),
    .i_req_write(p_wr[2][1:0]), .i_req_addr(p_adr[2][7:0]), .i_req_wstrb(p_stb[2][15:0]),
    .i_req_wdata(p_wd[2][127:0]), .o_resp_valid(rv_c), .o_resp_rdata(v_rd[2]),
    .o_mem_req(v_mreq[2]), .o_mem_we(v_mwe[2]), .o_mem_addr(v_maddr[2]),
    .o_mem_wstrb(v_mstrb[2]), .o_mem_wdata(v_mwd[2]), .i_mem_rdata(v_mrd[2])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int j = 0; j < 4; j++) if (v[j]) return j;
    return -1;
  endfunction

  function automatic exp_t mk(input int i, input int unsigned c, input int k);
    exp_t e;
    e.inst  = i;
    e.cyc   = c;
    e.id    = k;
    e.we    = wr[i][k];
    e.addr  = adr[i][k];
    e.wstrb = stb[i][k];
    e.wdata = wd[i][k];
    e.rdata = wr[i][k] ? 64'h0 : mem_val(adr[i][k]);
    return e;
  endfunction

  // monitor: acceptance pushes expectations, memory strobes and responses pop them
  exp_t me, re;
  int   mk_k, g;
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        if (v_rdy[i] != 4'h0) begin
          mk_k = oh_idx(v_rdy[i]);
          chk("ready_onehot", 64'($countones(v_rdy[i])), 64'd1);
          if (gq.size() == 0) note_fail("grant_unexpected");
          else begin
            g = gq.pop_front();
            chk("grant", 64'(i * 4 + mk_k), 64'(g));
          end
          qm.push_back(mk(i, cyc + 1, mk_k));
          qr.push_back(mk(i, cyc + 2 + lat(i), mk_k));
          acc_cnt[i]++;
          acc_cyc[i] = cyc;
        end
        if (v_mreq[i]) begin
          if (qm.size() == 0) note_fail("mem_req_unexpected");
          else begin
            me = qm.pop_front();
            chk("mem_inst", 64'(i), 64'(me.inst));
            chk("mem_cycle", 64'(cyc), 64'(me.cyc));
            chk("mem_we", 64'(v_mwe[i]), 64'(me.we));
            chk("mem_addr", 64'(v_maddr[i]), 64'(me.addr));
            chk("mem_wstrb", 64'(v_mstrb[i]), 64'(me.wstrb));
            chk("mem_wdata", v_mwd[i], me.wdata);
          end
        end
        if (v_rv[i] != 4'h0) begin
          if (qr.size() == 0) note_fail("resp_unexpected");
          else begin
            re = qr.pop_front();
            chk("resp_inst", 64'(i), 64'(re.inst));
            chk("resp_cycle", 64'(cyc), 64'(re.cyc));
            chk("resp_valid", 64'(v_rv[i]), 64'(4'b0001 << re.id));
            chk("resp_rdata", v_rd[i], re.rdata);
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input int k, input logic w, input logic [3:0] a,
                         input logic [7:0] s, input logic [63:0] d);
    wr[i][k] = w; adr[i][k] = a; stb[i][k] = s; wd[i][k] = d;
  endtask

  // hold valid=mask until n acceptances; first must be same-cycle, later ones gap apart
  task automatic run(input int i, input logic [3:0] mask, input int n, input int gap);
    int start, seen;
    int unsigned t0, last;
    start = acc_cnt[i]; seen = 0; t0 = cyc; last = 0;
    valid[i] = mask;
    for (int c = 0; c < 200 && seen < n; c++) begin
      @(negedge clk); #1;
      if (acc_cnt[i] != start + seen) begin
        if (seen == 0)    chk("first_accept_cycle", 64'(acc_cyc[i]), 64'(t0));
        else if (gap > 0) chk("accept_spacing", 64'(acc_cyc[i] - last), 64'(gap));
        last = acc_cyc[i];
        seen++;
      end
    end
    if (seen < n) note_fail("accept_timeout");
    @(posedge clk); #1;
    valid[i] = '0;
  endtask

  task automatic drain();
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (qm.size() == 0 && qr.size() == 0) return;
    end
    note_fail("drain_timeout");
  endtask

  task automatic chk_idle(input int i);
    chk("idle_ready", 64'(v_rdy[i]), 64'h0);
    chk("idle_resp_valid", 64'(v_rv[i]), 64'h0);
    chk("idle_mem_req", 64'(v_mreq[i]), 64'h0);
    chk("idle_mem_we", 64'(v_mwe[i]), 64'h0);
    chk("idle_mem_addr", 64'(v_maddr[i]), 64'h0);
    chk("idle_mem_wstrb", 64'(v_mstrb[i]), 64'h0);
    chk("idle_mem_wdata", v_mwd[i], 64'h0);
    chk("idle_resp_rdata", v_rd[i], 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 3'b000;
    for (int i = 0; i < 3; i++) begin
      valid[i] = '0;
      for (int k = 0; k < 4; k++) set_req(i, k, 1'b0, 4'h0, 8'h00, 64'h0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle(i);
    @(posedge clk); #1;
    nrst   = 3'b111;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // single read, then single write on the L=1 instance
    set_req(0, 0, 1'b0, 4'h3, 8'h00, 64'h0);
    gq.push_back(0);
    run(0, 4'b0001, 1, 0);
    drain();
    set_req(0, 1, 1'b1, 4'hA, 8'h0F, 64'h1122334455667788);
    gq.push_back(1);
    run(0, 4'b0010, 1, 0);
    drain();

    // both requesters valid continuously from reset: strict alternation, 4 cycles apart
    nrst[0] = 1'b0;
    @(posedge clk); #1;
    nrst[0] = 1'b1;
    set_req(0, 0, 1'b0, 4'h5, 8'h00, 64'h0);
    set_req(0, 1, 1'b1, 4'h7, 8'hFF, 64'hCAFEF00D_5A5A5A5A);
    for (int t = 0; t < 8; t++) gq.push_back(t % 2);
    run(0, 4'b0011, 8, 4);
    drain();

    // reset while waiting on read data: transaction dropped, pointer back to 0
    set_req(0, 0, 1'b0, 4'h3, 8'h00, 64'h0);
    gq.push_back(0);
    run(0, 4'b0001, 1, 0);
    @(posedge clk); #1;
    nrst[0] = 1'b0;
    qr.delete();
    @(posedge clk); #1;
    nrst[0] = 1'b1;
    @(negedge clk);
    chk_idle(0);
    @(posedge clk); #1;
    set_req(0, 0, 1'b0, 4'h1, 8'h00, 64'h0);
    set_req(0, 1, 1'b0, 4'h2, 8'h00, 64'h0);
    gq.push_back(0);
    gq.push_back(1);
    run(0, 4'b0011, 2, 4);
    drain();
    set_req(0, 1, 1'b1, 4'hE, 8'hF0, 64'h0F0F0F0F_F0F0F0F0);
    gq.push_back(1);
    run(0, 4'b0010, 1, 0);
    drain();

    // NREQ=3, RD_LATENCY=3: lone req2 granted at once, then rotation restarts at 0
    set_req(1, 2, 1'b0, 4'h9, 8'h00, 64'h0);
    gq.push_back(6);
    run(1, 4'b0100, 1, 0);
    drain();
    set_req(1, 0, 1'b0, 4'h3, 8'h00, 64'h0);
    set_req(1, 1, 1'b1, 4'h4, 8'h3C, 64'h0123456789ABCDEF);
    gq.push_back(4);
    gq.push_back(5);
    gq.push_back(6);
    run(1, 4'b0111, 3, 6);
    drain();

    // RD_LATENCY=0: data taken in the strobe cycle, back-to-back grants 3 cycles apart
    set_req(2, 0, 1'b0, 4'h3, 8'h00, 64'h0);
    gq.push_back(8);
    gq.push_back(8);
    run(2, 4'b0001, 2, 3);
    drain();

    repeat (4) @(posedge clk);
    chk("mem_queue_empty", 64'(qm.size()), 64'h0);
    chk("resp_queue_empty", 64'(qr.size()), 64'h0);
    chk("grant_queue_empty", 64'(gq.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kc705_slv_req_arbiter.md
Name: kc705_slv_req_arbiter

Overview:
Round-robin arbiter and sequencer for the single-port request interface of the KC705 test slave (req / addr / wstrb / wdata / rdata). It shares that port between NREQ requesters, for example the AXI4 slave adapter and a debug/self-test engine. Each transaction is sequenced as grant → memory strobe → fixed read-latency wait → one-cycle response. It sits in kc705_top between the requesters and the slave register/memory array.

Parameters:
NREQ, 2, number of requesters (2..4)
ABITS, 4, request address width (matches the 4-bit slave address)
DBITS, 64, data width; strobe width is DBITS/8
RD_LATENCY, 1, cycles from o_mem_req to valid i_mem_rdata (0..3)

Ports:
i_clk  in  1  system clock
i_nrst  in  1  synchronous reset, active low
i_req_valid  in  NREQ  per-requester request
o_req_ready  out  NREQ  one-hot acceptance, combinational from state and i_req_valid
i_req_write  in  NREQ  1=write, 0=read
i_req_addr  in  NREQ*ABITS  packed addresses; requester k at [k*ABITS +: ABITS]
i_req_wstrb  in  NREQ*DBITS/8  packed byte strobes
i_req_wdata  in  NREQ*DBITS  packed write data
o_resp_valid  out  NREQ  one-hot, one-cycle response pulse
o_resp_rdata  out  DBITS  read data, or 0 for writes
o_mem_req  out  1  one-cycle access strobe to the slave
o_mem_we  out  1  write enable, qualified by o_mem_req
o_mem_addr  out  ABITS  registered address
o_mem_wstrb  out  DBITS/8  registered strobes
o_mem_wdata  out  DBITS  registered write data
i_mem_rdata  in  DBITS  slave read data

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is synchronous, active low, on i_nrst; it is sampled only on the i_clk rising edge.
- Reset values: state=IDLE, rr_ptr=0, all outputs 0, o_resp_rdata=0.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE, arbitration:
  - Search i_req_valid starting at rr_ptr, wrapping NREQ-1 → 0. The first set bit k is the grant.
  - o_req_ready[k]=1 in the same cycle. No other ready bit is set. If no request is valid, all ready bits are 0.
  - On that edge, latch k, write, addr, wstrb and wdata from slice k. Set rr_ptr=(k+1) mod NREQ. Go to ACCESS.
- ACCESS (cycle T+1 after acceptance at T):
  - o_mem_req=1 for exactly one cycle; o_mem_we=latched write; addr/wstrb/wdata driven from registers.
  - Go to WAIT if RD_LATENCY>0, otherwise capture i_mem_rdata this cycle and go to RESP.
- WAIT: down-counter loaded with RD_LATENCY-1. Capture i_mem_rdata in the cycle the counter reaches 0, i.e. cycle T+1+RD_LATENCY, then go to RESP.
- Write transactions capture 0 instead of i_mem_rdata.
- RESP (cycle T+2+RD_LATENCY):
  - o_resp_valid[k]=1 for one cycle; o_resp_rdata=captured value.
  - Return to IDLE. o_resp_rdata holds its value until the next RESP.
- Throughput: one transaction per 3+RD_LATENCY cycles. No new grant is made outside IDLE.
- Requester contract: a requester keeps valid and payload stable until it sees ready. Deasserting valid before ready drops that request, with no side effects.
- Masking: o_mem_addr/wstrb/wdata may hold stale values when o_mem_req=0; the slave must ignore them.
- Persistent requester: a requester holding valid after its response is eligible again. It is granted only when its turn comes in the round-robin.
- Simultaneous valid from all requesters: grants rotate k, k+1, …, so no requester starves.
- Reset mid-transaction:
  - Return to IDLE immediately; no o_resp_valid is issued for the aborted transaction.
  - o_mem_req drops in the next cycle.
  - rr_ptr returns to 0.
- Width rule: wstrb width is DBITS/8. Packed slices are unsigned with no padding.

Decomposition:
- Package kc705_slv_arb_pkg holds:
  - the state enum (IDLE/ACCESS/WAIT/RESP);
  - the req_slot_t struct {write, addr, wstrb, wdata};
  - localparam CFG_SLV_ARB_NREQ_MAX=4.
- Sub-module rr_arbiter (NREQ): inputs request vector and pointer; outputs one-hot grant and grant index. It is purely combinational and reused by other arbiters.
- The FSM, counter and capture registers stay in the top module.

Test Plan:
1. Reset, then req0 read addr=4'h3, memory returns 64'hDEADBEEF_01234567 at T+2 → o_req_ready[0] at T, o_mem_req at T+1 with we=0 and addr=3, o_resp_valid=2'b01 at T+3 with rdata=64'hDEADBEEF_01234567.
2. req1 write addr=4'hA, wstrb=8'h0F, wdata=64'h1122334455667788 → o_mem_req=1, we=1, wstrb=0F, wdata echoed at T+1; o_resp_valid=2'b10 at T+3 with rdata=0.
3. Both valid continuously for 8 transactions from reset → grant order 0,1,0,1,…; each response 4 cycles apart; no double grant.
4. NREQ=3, RD_LATENCY=3, only req2 valid → granted immediately despite rr_ptr=0; response at T+5; rr_ptr becomes 0.
5. i_nrst=0 asserted in WAIT → no o_resp_valid; all outputs 0 next cycle; after release, a fresh req1 is granted normally.
6. RD_LATENCY=0, req0 read → rdata sampled during the o_mem_req cycle; response at T+2; next grant possible at T+3.
